// File: rtl/seq_framer_tx.sv
// seq_framer_tx
// Serial frame transmitter. An accepted WIDTH-bit word is sent as a frame:
// two flag bits (1,1), a separator (0), then the payload MSB first. A 0 is
// inserted after every payload 1. The 1,1 pattern therefore occurs only in
// the flag, and a receiver can find frame starts from it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   data_in    payload word, captured on acceptance
//   valid_in   data_in is valid
//   ready_out  block can accept a word (high only in IDLE)
//   out        serial bit stream, one bit per clk
//   busy       a frame is in progress
//   last       out carries the final bit of the frame
//   dbg_state  current FSM state encoding (IDLE=0 .. STUFF=5)
//
// Handshake: a word transfers on a rising edge where valid_in and ready_out
// are both 1. ready_out does not depend on valid_in. valid_in while busy is
// ignored and is not queued. The producer may change data_in freely after
// the transfer.
//
// All outputs decode registered state only. There is no combinational path
// from any input to any output.
module seq_framer_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out,
  output logic             busy,
  output logic             last,
  output logic [2:0]       dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLAG1 = 3'd1,
    FLAG2 = 3'd2,
    SEP   = 3'd3,
    DATA  = 3'd4,
    STUFF = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  sreg;
  logic [CW-1:0]     cnt;   // index of the payload bit in flight
  logic              msb;
  logic              at_last;

  assign msb       = sreg[WIDTH-1];
  assign at_last   = (cnt == LAST_IDX);
  assign dbg_state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = FLAG1;
      FLAG1:   state_d = FLAG2;
      FLAG2:   state_d = SEP;
      SEP:     state_d = DATA;
      DATA: begin
        if (msb)          state_d = STUFF;
        else if (at_last) state_d = IDLE;
        else              state_d = DATA;
      end
      STUFF:   state_d = at_last ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
  end

  // Shift register and bit counter. The counter advances only when a payload
  // bit is complete. That is at DATA exit on a 0, or at STUFF exit after a 1.
  // The counter holds at LAST_IDX, so it never passes WIDTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_in) sreg <= data_in;
        end
        SEP: begin
          cnt <= '0;
        end
        DATA: begin
          sreg <= {sreg[WIDTH-2:0], 1'b0};
          if (!msb && !at_last) cnt <= cnt + CW'(1);
        end
        STUFF: begin
          if (!at_last) cnt <= cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    out       = 1'b0;
    ready_out = 1'b0;
    busy      = 1'b1;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        ready_out = 1'b1;
        busy      = 1'b0;
      end
      FLAG1, FLAG2: out = 1'b1;
      SEP:          out = 1'b0;
      DATA: begin
        out  = msb;
        last = at_last && !msb;
      end
      STUFF: begin
        out  = 1'b0;
        last = at_last;
      end
      default: begin
        ready_out = 1'b1;
        busy      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_framer_tx.sv
// Directed and scoreboarded bench for seq_framer_tx (WIDTH=8).
module tb_seq_framer_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       out;
  logic       busy;
  logic       last;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  seq_framer_tx #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .out       (out),
    .busy      (busy),
    .last      (last),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a word in IDLE for one edge. valid_in drops afterwards and data_in
  // is scrambled.
  task automatic send_word(input logic [7:0] w);
    valid_in = 1'b1;
    data_in  = w;
    tick();
    valid_in = 1'b0;
    data_in  = 8'($urandom);
  endtask

  // Record the frame from the current (FLAG1) cycle until busy drops.
  // bits holds the stream with the first bit at position len-1.
  // While the frame runs, inputs are scrambled. In hold mode, valid_in stays
  // 1 and next_w is presented during the last cycle. In the other mode,
  // valid_in is dropped during the last cycle.
  task automatic grab_frame(input bit hold, input logic [7:0] next_w,
                            output logic [63:0] bits, output int len,
                            output int last_cnt, output int last_pos,
                            output int rdy_bad);
    bits = '0; len = 0; last_cnt = 0; last_pos = 0; rdy_bad = 0;
    while (busy && len < 40) begin
      bits = {bits[62:0], out};
      len++;
      if (ready_out) rdy_bad++;
      if (last) begin
        last_cnt++;
        last_pos = len;
      end
      if (last) begin
        data_in  = hold ? next_w : 8'($urandom);
        valid_in = hold;
      end else begin
        data_in  = 8'($urandom);
        valid_in = hold ? 1'b1 : 1'($urandom);
      end
      tick();
    end
    if (len >= 40) check("frame_timeout", 64'(len), 64'd0);
  endtask

  // Build the expected stream from the frame format: flag, separator, then
  // each payload bit with a 0 after every 1.
  function automatic void model(input logic [7:0] w, output logic [63:0] bits, output int len);
    bits = 64'b110;
    len  = 3;
    for (int i = 7; i >= 0; i--) begin
      bits = {bits[62:0], w[i]}; len++;
      if (w[i]) begin bits = {bits[62:0], 1'b0}; len++; end
    end
  endfunction

  // Receiver: find the flag, then destuff the payload. err counts format
  // violations.
  function automatic void decode(input logic [63:0] bits, input int len,
                                 output logic [7:0] w, output int err);
    int i;
    int nb;
    w = '0; err = 0; nb = 0;
    if (len < 11 || bits[len-1] !== 1'b1 || bits[len-2] !== 1'b1 || bits[len-3] !== 1'b0) err++;
    i = len - 4;
    while (i >= 0 && nb < 8) begin
      w = {w[6:0], bits[i]};
      nb++;
      if (bits[i]) begin
        if (i == 0 || bits[i-1] !== 1'b0) err++;
        i -= 2;
      end else begin
        i -= 1;
      end
    end
    if (nb != 8 || i != -1) err++;
  endfunction

  function automatic int popcount8(input logic [7:0] w);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(w[i]);
    return c;
  endfunction

  logic [63:0] bits, ebits;
  int len, elen, lc, lp, rb, err;
  logic [7:0] w, got;

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = 8'h00;
    tick(); tick();
    check("rst_out", out, 0);
    check("rst_busy", busy, 0);
    check("rst_last", last, 0);
    check("rst_ready", ready_out, 1);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick();

    // A5
    send_word(8'hA5);
    grab_frame(1'b0, 8'h00, bits, len, lc, lp, rb);
    check("a5_len", len, 15);
    check("a5_bits", bits, 64'b110100100010010);
    check("a5_last_pos", lp, 15);
    check("a5_last_cnt", lc, 1);
    check("a5_ready_low", rb, 0);
    check("a5_ready_after", ready_out, 1);
    check("a5_out_after", out, 0);

    // 00
    send_word(8'h00);
    grab_frame(1'b0, 8'h00, bits, len, lc, lp, rb);
    check("00_len", len, 11);
    check("00_bits", bits, 64'b11000000000);
    check("00_last_pos", lp, 11);

    // FF
    send_word(8'hFF);
    grab_frame(1'b0, 8'h00, bits, len, lc, lp, rb);
    check("ff_len", len, 19);
    check("ff_bits", bits, 64'b1101010101010101010);
    check("ff_last_pos", lp, 19);
    check("ff_last_cnt", lc, 1);

    // Back-to-back 81 / 7E with valid_in held high
    valid_in = 1'b1; data_in = 8'h81;
    tick();
    grab_frame(1'b1, 8'h7E, bits, len, lc, lp, rb);
    check("81_len", len, 13);
    check("81_bits", bits, 64'b1101000000010);
    check("gap_busy", busy, 0);
    check("gap_out", out, 0);
    tick();
    check("gap_one_cycle", busy, 1);
    grab_frame(1'b1, 8'h81, bits, len, lc, lp, rb);
    check("7e_len", len, 17);
    check("7e_bits", bits, 64'b11001010101010100);
    check("7e_last_cnt", lc, 1);
    valid_in = 1'b0;
    tick();

    // Mid-frame reset during the 6th frame cycle
    send_word(8'hA5);
    lc = 0;
    for (int i = 0; i < 5; i++) begin
      if (last) lc++;
      tick();
    end
    if (last) lc++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out", out, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", ready_out, 1);
    check("abort_last", last, 0);
    tick();
    check("abort_stay_idle", busy, 0);
    check("abort_no_last", lc, 0);

    // Reset has priority over acceptance
    rst = 1'b1; valid_in = 1'b1; data_in = 8'hFF;
    tick();
    rst = 1'b0; valid_in = 1'b0;
    check("rst_prio_busy", busy, 0);
    tick();
    check("rst_prio_idle", busy, 0);
    check("rst_prio_out", out, 0);

    // Random scoreboard through a flag detector and destuffer
    for (int k = 0; k < 24; k++) exp_q.push_back(8'($urandom_range(0, 255)));
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      send_word(w);
      grab_frame(1'b0, 8'h00, bits, len, lc, lp, rb);
      decode(bits, len, got, err);
      model(w, ebits, elen);
      check("sb_word", got, w);
      check("sb_fmt", err, 0);
      check("sb_len", len, 11 + popcount8(w));
      check("sb_stream", bits, ebits);
      check("sb_last", lp, len);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Cycle cap so the run always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
